// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch controller for the pipeline's single-port instruction
// memory. Owns the fetch PC and presents it to the memory. An instruction is
// accepted only when the memory flags it valid. Accepted instructions enter a
// small queue, and decode drains that queue through a valid/ready handshake.
// The block also handles redirects, halt requests and out-of-range faults.
//
// Parameters
//   RESET_PC   fetch PC loaded at reset
//   DEPTH      instruction queue entries (power of two, >= 2)
//   MEM_BYTES  instruction memory size in bytes
//
// Ports
//   clk             clock; all state updates on the rising edge
//   rst             asynchronous active-low reset
//   imem_pc         address to instruction memory (the fetch_pc register)
//   imem_instr      instruction for the address held over the previous edge
//   imem_valid      imem_instr is valid for the current imem_pc
//   out_valid       queue head valid
//   out_ready       decode accepts the head
//   out_pc          PC of the head instruction
//   out_instr       head instruction
//   redirect_valid  flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch PC (low two bits dropped; nonzero sets fault)
//   halt_req        level request to stop fetching
//   halted          fetch stopped and queue empty
//   fault           sticky; out-of-range fetch or misaligned redirect
//
// State      | meaning
// -----------+-----------------------------------------------------------
// S_FETCH    | fetching; a valid memory word is pushed if there is room
// S_FULL     | queue holds DEPTH entries; wait for a pop
// S_HALTING  | halt requested; no pushes, queue draining
// S_HALTED   | halt requested and queue empty
// S_FAULT    | fetch PC out of range; queue drains; only a redirect exits
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          DEPTH     = 2,
    parameter int          MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    input  logic        imem_valid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_FULL,
        S_HALTING,
        S_HALTED,
        S_FAULT
    } state_t;

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [32:0]      MEM_LIMIT = 33'(MEM_BYTES);

    state_t            state_q;
    state_t            state_d;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       fetch_pc_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [31:0]       pc_mem    [DEPTH];
    logic [31:0]       instr_mem [DEPTH];
    logic              fault_q;

    logic              pop;
    logic              space;
    logic              in_range;
    logic              fetch_ok;
    logic              push;
    logic              range_fault;
    logic              misaligned;

    assign pop        = (count_q != '0) && out_ready;
    assign space      = (count_q < DEPTH_C) || pop;
    // 33-bit sum so a fetch PC near the top of the address space cannot wrap
    // back into range.
    assign in_range   = ({1'b0, fetch_pc_q} + 33'd3) < MEM_LIMIT;
    // A push would happen here if the address were in range. The same
    // qualifier decides whether an out-of-range PC faults, so a stalled or
    // halting fetch never faults on its own.
    assign fetch_ok   = (state_q == S_FETCH) && imem_valid && !redirect_valid
                        && !halt_req && space;
    assign push       = fetch_ok && in_range;
    assign range_fault = fetch_ok && !in_range;
    assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Queue occupancy. A redirect empties the queue. A pop in the same cycle
    // still completes, because decode already sampled the head.
    always_comb begin
        count_d = count_q;
        if (redirect_valid) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end else if (push) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = halt_req ? S_HALTING : S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (halt_req) begin
                        state_d = (count_d == '0) ? S_HALTED : S_HALTING;
                    end else if (range_fault) begin
                        state_d = S_FAULT;
                    end else if (count_d == DEPTH_C) begin
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (halt_req) begin
                        state_d = (count_d == '0) ? S_HALTED : S_HALTING;
                    end else if (pop) begin
                        state_d = S_FETCH;
                    end
                end
                S_HALTING: begin
                    if (!halt_req) begin
                        state_d = S_FETCH;
                    end else if (count_d == '0) begin
                        state_d = S_HALTED;
                    end
                end
                S_HALTED: begin
                    if (!halt_req) begin
                        state_d = S_FETCH;
                    end
                end
                S_FAULT: begin
                    state_d = S_FAULT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FETCH;
            fetch_pc_q <= RESET_PC;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            if (range_fault || misaligned) begin
                fault_q <= 1'b1;
            end
        end
    end

    // Queue pointers and storage. Storage is reset so out_pc and out_instr
    // read zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
            end
        end else if (redirect_valid) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr_q]    <= fetch_pc_q;
                instr_mem[wr_ptr_q] <= imem_instr;
                wr_ptr_q            <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign imem_pc   = fetch_pc_q;
    assign out_valid = (count_q != '0);
    assign out_pc    = pc_mem[rd_ptr_q];
    assign out_instr = instr_mem[rd_ptr_q];
    assign halted    = (state_q == S_HALTED);
    assign fault     = fault_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch controller sequencing the single-port instruction memory of the pipeline. It owns the fetch PC, drives it to the memory, and accepts the registered instruction only when the memory flags it valid. Accepted instructions go into a small queue presented to decode with a valid/ready handshake. It also handles branch/jump redirects, halt requests and out-of-range fetch faults.

## Interface
- RESET_PC, 32'h0000_0000, fetch PC loaded at reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)
- MEM_BYTES, 4096, instruction memory size in bytes
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_pc  out  32  address to instruction memory; equals the fetch_pc register
- imem_instr  in  32  instruction for the address presented on the previous edge
- imem_valid  in  1  imem_instr is valid for the current imem_pc
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  PC of head instruction
- out_instr  out  32  head instruction
- redirect_valid  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch PC
- halt_req  in  1  level; stop fetching
- halted  out  1  fetch stopped and queue empty
- fault  out  1  sticky; fetch address out of range or misaligned redirect

## Operation
- States: FETCH, FULL, HALTING, HALTED, FAULT.
- Memory contract: imem_instr is registered from the address held at the previous edge. imem_valid=1 only when imem_pc was unchanged over that edge and reset is not in its first cycle.
- Push condition: state FETCH, imem_valid=1, no redirect, and (count<DEPTH or pop this cycle).
- On push: enqueue {fetch_pc, imem_instr}; fetch_pc <= fetch_pc+4 (32-bit wrap).
- Pop: out_valid && out_ready. Push and pop may occur in the same cycle; count is unchanged.
- FETCH→FULL when count reaches DEPTH with no pop. FULL→FETCH on pop.
- halt_req=1 in FETCH/FULL→HALTING: no further pushes; queue keeps draining. HALTING→HALTED when count==0; halted=1 in HALTED.
- halt_req=0 in HALTING/HALTED→FETCH. fetch_pc is kept and the queue is not flushed.
- Range check: before a push, if fetch_pc+3 ≥ MEM_BYTES, do not push; enter FAULT and set fault=1. Queue still drains.
- Redirect (any state, highest priority):
  - queue count←0 and fetch_pc←{redirect_pc[31:2],2'b00}; state←FETCH, or HALTING if halt_req=1.
  - A pop occurring in the same cycle completes; all other entries are discarded.
  - Any imem_instr arriving that cycle is dropped.
  - If redirect_pc[1:0]≠0, set fault, but fetch still proceeds (state not FAULT).
- FAULT exits only via redirect. fault clears only on reset.

## Timing
- Reset (async assert):
  - fetch_pc=RESET_PC, count=0, state=FETCH.
  - out_valid=0, halted=0, fault=0, out_pc=0, out_instr=0.
- Deassert is synchronised by the system; the first edge after deassert yields no push (imem_valid=0).
- Fetch latency: a new fetch_pc at edge N gives imem_valid at edge N+1 and a push at edge N+2. Steady throughput is 1 instruction per 2 cycles.
- Queue latency: a pushed entry is visible on out_* the cycle after the push edge. out_* are registered from queue storage, with no combinational path from imem_*.
- Redirect latency: fetch_pc=redirect_pc at the next edge, and the first push 2 cycles later. out_valid=0 the cycle after the redirect.
- halted asserts the cycle after the final pop in HALTING, or the cycle after halt_req if the queue is already empty.
- out_ready is allowed to toggle freely. out_pc/out_instr stay stable while out_valid=1 and out_ready=0.

## Test plan
- Reset, out_ready=1, memory word i = 0x1000_0000+i:
  - out_pc sequence 0,4,8,… with matching instr, one every 2 cycles.
  - First out_valid on the 3rd edge after reset release.
- out_ready=0 for 10 cycles:
  - count saturates at DEPTH, state FULL, imem_pc frozen at 0x8.
  - Release → entries 0x0,0x4 popped in order, fetch resumes at 0x8.
- Queue holding 0x8,0xC, assert redirect_valid with redirect_pc=0x40:
  - out_valid=0 next cycle.
  - Next out_pc=0x40; 0x8/0xC are never seen.
- redirect_pc=0x42:
  - fault=1 and fetch from 0x40.
  - fault stays 1 after further redirects until rst asserted low.
- With 2 entries queued, raise halt_req:
  - Pop both → halted=1 one cycle later, no further pushes.
  - Drop halt_req → fetch resumes at next sequential PC.
- Redirect to MEM_BYTES-4 with MEM_BYTES=4096:
  - Instruction at 0xFFC delivered.
  - Next fetch (0x1000) → FAULT, fault=1, no push.
  - Redirect to 0x0 → fetch restarts.
